// File: rtl/exception_sequencer_if.sv
// Handshake and status bundle between the exception sequencer and the
// address-generation, memory-arbiter and fetch stages.
interface exception_sequencer_if;
  logic [2:0]  fault_valid;
  logic [31:0] fault_eip;
  logic [15:0] cur_cs;
  logic [31:0] cur_eflags;
  logic [31:0] cur_esp;
  logic        flush;
  logic        busy;
  logic        push_valid;
  logic        push_ready;
  logic        push_error;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic        idt_rd_valid;
  logic        idt_rd_ready;
  logic [31:0] idt_rd_addr;
  logic        idt_rd_data_valid;
  logic [63:0] idt_rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_eip;
  logic [15:0] redirect_cs;
  logic        esp_wr_valid;
  logic [31:0] esp_wr_data;
  logic        clr_if;
  logic        shutdown;

  modport master (
    input  fault_valid, fault_eip, cur_cs, cur_eflags, cur_esp,
    input  push_ready, push_error, idt_rd_ready, idt_rd_data_valid, idt_rd_data,
    output flush, busy, push_valid, push_addr, push_data, idt_rd_valid, idt_rd_addr,
    output redirect_valid, redirect_eip, redirect_cs, esp_wr_valid, esp_wr_data,
    output clr_if, shutdown
  );

  modport slave (
    output fault_valid, fault_eip, cur_cs, cur_eflags, cur_esp,
    output push_ready, push_error, idt_rd_ready, idt_rd_data_valid, idt_rd_data,
    input  flush, busy, push_valid, push_addr, push_data, idt_rd_valid, idt_rd_addr,
    input  redirect_valid, redirect_eip, redirect_cs, esp_wr_valid, esp_wr_data,
    input  clr_if, shutdown
  );
endinterface

// File: rtl/exception_sequencer.sv
// Limit-fault exception delivery: latch fault, flush, push EFLAGS/CS/EIP,
// fetch the IDT gate and redirect fetch; a push fault locks into shutdown.
module exception_sequencer #(
  parameter logic [31:0] IDT_BASE  = 32'h0000_0000,
  parameter logic [7:0]  GP_VECTOR = 8'd13,
  parameter logic [7:0]  SS_VECTOR = 8'd12
) (
  input logic                   clk,
  input logic                   reset,
  exception_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StFlush, StPushFl, StPushCs, StPushIp,
    StIdtReq, StIdtWait, StRedirect, StShutdown
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] eip_q, eflags_q, esp_q, handler_eip_q;
  logic [15:0] cs_q, handler_cs_q;
  logic [7:0]  vector_q;
  logic        capture, gate_load;

  assign bus.busy         = (state_q != StIdle);
  assign bus.redirect_eip = handler_eip_q;
  assign bus.redirect_cs  = handler_cs_q;

  always_comb begin
    state_d            = state_q;
    capture            = 1'b0;
    gate_load          = 1'b0;
    bus.flush          = 1'b0;
    bus.push_valid     = 1'b0;
    bus.push_addr      = '0;
    bus.push_data      = '0;
    bus.idt_rd_valid   = 1'b0;
    bus.idt_rd_addr    = '0;
    bus.redirect_valid = 1'b0;
    bus.esp_wr_valid   = 1'b0;
    bus.esp_wr_data    = '0;
    bus.clr_if         = 1'b0;
    bus.shutdown       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|bus.fault_valid) begin
          capture = 1'b1;
          state_d = StFlush;
        end
      end
      StFlush: begin
        bus.flush = 1'b1;
        state_d   = StPushFl;
      end
      StPushFl: begin
        bus.push_valid = 1'b1;
        bus.push_addr  = esp_q - 32'd4;
        bus.push_data  = eflags_q;
        if (bus.push_ready) state_d = bus.push_error ? StShutdown : StPushCs;
      end
      StPushCs: begin
        bus.push_valid = 1'b1;
        bus.push_addr  = esp_q - 32'd8;
        bus.push_data  = {16'h0000, cs_q};
        if (bus.push_ready) state_d = bus.push_error ? StShutdown : StPushIp;
      end
      StPushIp: begin
        bus.push_valid = 1'b1;
        bus.push_addr  = esp_q - 32'd12;
        bus.push_data  = eip_q;
        if (bus.push_ready) state_d = bus.push_error ? StShutdown : StIdtReq;
      end
      StIdtReq: begin
        bus.idt_rd_valid = 1'b1;
        bus.idt_rd_addr  = IDT_BASE + {21'b0, vector_q, 3'b000};
        if (bus.idt_rd_ready) state_d = StIdtWait;
      end
      StIdtWait: begin
        if (bus.idt_rd_data_valid) begin
          gate_load = 1'b1;
          state_d   = StRedirect;
        end
      end
      StRedirect: begin
        bus.redirect_valid = 1'b1;
        bus.esp_wr_valid   = 1'b1;
        bus.esp_wr_data    = esp_q - 32'd12;
        bus.clr_if         = 1'b1;
        state_d            = StIdle;
      end
      StShutdown: begin
        bus.shutdown = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      eip_q         <= '0;
      eflags_q      <= '0;
      esp_q         <= '0;
      cs_q          <= '0;
      vector_q      <= '0;
      handler_eip_q <= '0;
      handler_cs_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        eip_q    <= bus.fault_eip;
        eflags_q <= bus.cur_eflags;
        esp_q    <= bus.cur_esp;
        cs_q     <= bus.cur_cs;
        // Operand checkers outrank the stack checker.
        vector_q <= (|bus.fault_valid[1:0]) ? GP_VECTOR : SS_VECTOR;
      end
      if (gate_load) begin
        handler_eip_q <= {bus.idt_rd_data[63:48], bus.idt_rd_data[15:0]};
        handler_cs_q  <= bus.idt_rd_data[31:16];
      end
    end
  end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Consumes limit-fault requests from the address-generation segment limit checkers: two operand checkers and one stack checker.
- Latches the first fault, flushes the pipeline, pushes EFLAGS/CS/EIP to the stack over a memory write handshake, reads the IDT gate, then redirects fetch.
- Sits between address generation, the memory arbiter and the fetch stage.
- A fault during delivery puts the block in a sticky shutdown state.

Parameters:
IDT_BASE, 32'h00000000, linear base address of the IDT (8-byte gates)
GP_VECTOR, 8'd13, vector for operand-checker faults
SS_VECTOR, 8'd12, vector for stack-checker faults

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fault_valid  in  3  [0]=op0 checker, [1]=op1 checker, [2]=stack checker
fault_eip  in  32  EIP of the instruction in the faulting stage
cur_cs  in  16  architectural CS
cur_eflags  in  32  architectural EFLAGS
cur_esp  in  32  architectural ESP
flush  out  1  one-cycle pipeline flush pulse
busy  out  1  high in every non-IDLE state
push_valid  out  1  stack write request
push_ready  in  1  write accepted
push_error  in  1  write faulted; qualified by push_valid&push_ready
push_addr  out  32  ESP-relative write address
push_data  out  32  write data
idt_rd_valid  out  1  IDT read request
idt_rd_ready  in  1  read accepted
idt_rd_addr  out  32  gate address
idt_rd_data_valid  in  1  gate data return
idt_rd_data  in  64  gate: [15:0] off_lo, [31:16] selector, [63:48] off_hi
redirect_valid  out  1  one-cycle fetch redirect pulse
redirect_eip  out  32  handler EIP
redirect_cs  out  16  handler CS
esp_wr_valid  out  1  ESP update, same cycle as redirect_valid
esp_wr_data  out  32  new ESP
clr_if  out  1  clear EFLAGS.IF, same cycle as redirect_valid
shutdown  out  1  sticky double-fault indicator

Behaviour:

Reset:
- State goes to IDLE.
- All outputs and internal latches are 0. This includes shutdown.
- Reset in any state, including mid-handshake, aborts immediately. No request stays asserted the following cycle.

IDLE:
- Capture happens on a cycle with any fault_valid bit set.
- Latch fault_eip, cur_cs, cur_eflags, cur_esp.
- Vector: GP_VECTOR if fault_valid[1:0] != 0, else SS_VECTOR (operand faults have priority).
- Next state is FLUSH.

FLUSH:
- flush=1 for exactly this cycle, which is capture+1.
- Next state is PUSH_FL.

PUSH_FL / PUSH_CS / PUSH_IP:
- Each state holds push_valid=1 and stable addr/data until push_ready.

| State | push_addr | push_data |
|---|---|---|
| PUSH_FL | esp-4 | eflags |
| PUSH_CS | esp-8 | {16'h0, cs} |
| PUSH_IP | esp-12 | eip |

- All arithmetic is mod 2^32; wrap is allowed and is not checked here.
- Advance on push_ready.
- push_ready & push_error in any push state goes to SHUTDOWN.

IDT_REQ:
- idt_rd_valid=1 and idt_rd_addr = IDT_BASE + {vector,3'b0}, held until idt_rd_ready.
- Next state is IDT_WAIT.

IDT_WAIT:
- Wait for idt_rd_data_valid.
- Latch redirect_eip = {off_hi, off_lo} and redirect_cs = selector.
- Next state is REDIRECT.

REDIRECT:
- For one cycle: redirect_valid=1, esp_wr_valid=1, esp_wr_data = esp-12, clr_if=1.
- Next state is IDLE.

SHUTDOWN:
- shutdown=1 and busy=1. All requests are 0.
- Exit only by reset.

General rules:
- fault_valid is ignored whenever busy=1; faults from flushed instructions are discarded.
- push_valid and idt_rd_valid are never asserted together.
- Minimum latency, with ready and data returning same-cycle: capture at cycle N, flush at N+1, pushes at N+2..N+4, IDT request at N+5, data at N+6, redirect at N+7.
- A fault asserted in the same cycle redirect_valid is high is ignored. A fault in the following IDLE cycle is captured normally.

Test Plan:
- Stack fault, all ready: fault_valid=3'b100, esp=32'h1000, eflags=32'h202, cs=16'h0008, eip=32'h00401234 → flush at N+1. Pushes (0xFFC, 0x202), (0xFF8, 0x8), (0xFF4, 0x401234). idt_rd_addr=32'h60. Gate 64'h0040_0000_0010_5678 → redirect_eip=32'h00405678, redirect_cs=16'h0010, esp_wr_data=32'hFF4 at N+7.
- Priority: fault_valid=3'b101 → vector 13, idt_rd_addr=32'h68.
- Backpressure: push_ready low for 3 cycles in PUSH_CS → addr 0xFF8 and data held stable; next push occurs only after acceptance.
- ESP wrap: esp=32'h00000004 → push addrs 32'h0, 32'hFFFFFFFC, 32'hFFFFFFF8; esp_wr_data=32'hFFFFFFF8.
- Double fault: push_error with push_ready in PUSH_IP → shutdown=1 stays set. A new fault_valid is ignored. Reset clears shutdown and busy on the next edge.
- Reset mid-IDT_WAIT, then fault_valid=3'b001 one cycle later → clean capture, with flush the cycle after capture.
